// File: rtl/gemm_tile_mem.sv
// gemm_tile_mem: 128-bit single-port tile memory for the GEMM engine.
// The engine always wins the port; the 32-bit host port uses idle cycles.
module gemm_tile_mem #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         interface_en,
  input  logic         interface_rdwr,
  input  logic [31:0]  interface_addr,
  input  logic [4:0]   interface_control,
  input  logic [127:0] interface_wr_data,
  output logic [127:0] interface_rd_data,
  input  logic         host_en,
  input  logic         host_rdwr,
  input  logic [31:0]  host_addr,
  input  logic [31:0]  host_wr_data,
  output logic         host_ready,
  output logic [31:0]  host_rd_data,
  output logic         host_rd_valid,
  output logic         err,
  output logic [31:0]  err_addr
);

  localparam int unsigned ROWS = 1 << DEPTH_LOG2;
  localparam int unsigned SPAN = DEPTH_LOG2 + 4;

  logic [127:0] mem [ROWS];

  logic [31:0]           e_off;
  logic [31:0]           h_off;
  logic                  e_ok;
  logic                  h_ok;
  logic                  h_acc;
  logic [DEPTH_LOG2-1:0] e_row;
  logic [DEPTH_LOG2-1:0] h_row;
  logic [6:0]            h_bit;
  logic                  e_we;
  logic                  h_we;
  logic                  bad;
  logic [31:0]           bad_addr;
  logic                  unused_ctl;

  assign unused_ctl = interface_control[4];

  assign host_ready = host_en & ~interface_en;
  assign h_acc      = host_ready;

  assign e_off = interface_addr - BASE_ADDR;
  assign h_off = host_addr - BASE_ADDR;

  assign e_ok = (interface_addr >= BASE_ADDR)
              && ((e_off >> SPAN) == 32'd0)
              && (interface_addr[3:0] == 4'd0);
  assign h_ok = (host_addr >= BASE_ADDR)
              && ((h_off >> SPAN) == 32'd0)
              && (host_addr[1:0] == 2'd0);

  assign e_row = e_off[SPAN-1:4];
  assign h_row = h_off[SPAN-1:4];
  assign h_bit = {host_addr[3:2], 5'd0};

  // No array write on an edge seen while reset is held.
  assign e_we = rst & interface_en & interface_rdwr & e_ok;
  assign h_we = rst & h_acc & host_rdwr & h_ok;

  // Pick the one accepted request whose address is checked this cycle.
  always_comb begin
    bad      = 1'b0;
    bad_addr = interface_addr;
    unique case (1'b1)
      interface_en: begin
        bad = ~e_ok;
      end
      h_acc: begin
        bad      = ~h_ok;
        bad_addr = host_addr;
      end
      default: ;
    endcase
  end

  // Array write: engine lanes by mask, else one host lane.
  always_ff @(posedge clk) begin
    if (e_we) begin
      for (int i = 0; i < 4; i++) begin
        if (interface_control[i])
          mem[e_row][32*i +: 32] <= interface_wr_data[32*i +: 32];
      end
    end else if (h_we) begin
      mem[h_row][h_bit +: 32] <= host_wr_data;
    end
  end

  // Registered read ports and the sticky error capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      interface_rd_data <= '0;
      host_rd_data      <= '0;
      host_rd_valid     <= 1'b0;
      err               <= 1'b0;
      err_addr          <= '0;
    end else begin
      host_rd_valid <= h_acc & ~host_rdwr;
      if (interface_en && !interface_rdwr)
        interface_rd_data <= e_ok ? mem[e_row] : '0;
      if (h_acc && !host_rdwr)
        host_rd_data <= h_ok ? mem[h_row][h_bit +: 32] : '0;
      if (bad) begin
        err <= 1'b1;
        if (!err)
          err_addr <= bad_addr;
      end
    end
  end

endmodule

// File: tb/tb_gemm_tile_mem.sv
// tb_gemm_tile_mem: random and directed traffic on both ports,
// compared against an array model of the tile memory.
module tb_gemm_tile_mem;

  localparam logic [31:0] BASE = 32'h0;

  logic         clk;
  logic         rst;
  logic         interface_en;
  logic         interface_rdwr;
  logic [31:0]  interface_addr;
  logic [4:0]   interface_control;
  logic [127:0] interface_wr_data;
  logic [127:0] interface_rd_data;
  logic         host_en;
  logic         host_rdwr;
  logic [31:0]  host_addr;
  logic [31:0]  host_wr_data;
  logic         host_ready;
  logic [31:0]  host_rd_data;
  logic         host_rd_valid;
  logic         err;
  logic [31:0]  err_addr;

  gemm_tile_mem #(
    .DEPTH_LOG2(10),
    .BASE_ADDR (BASE)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .interface_en     (interface_en),
    .interface_rdwr   (interface_rdwr),
    .interface_addr   (interface_addr),
    .interface_control(interface_control),
    .interface_wr_data(interface_wr_data),
    .interface_rd_data(interface_rd_data),
    .host_en          (host_en),
    .host_rdwr        (host_rdwr),
    .host_addr        (host_addr),
    .host_wr_data     (host_wr_data),
    .host_ready       (host_ready),
    .host_rd_data     (host_rd_data),
    .host_rd_valid    (host_rd_valid),
    .err              (err),
    .err_addr         (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [127:0] mdl [16];
  logic [127:0] m_rd;
  logic [31:0]  m_hrd;
  bit           m_hv;
  bit           m_err;
  logic [31:0]  m_eaddr;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit ok(input logic [31:0] a, input bit eng);
    longint x;
    longint b;
    x = longint'({32'd0, a});
    b = longint'({32'd0, BASE});
    if (x < b || x >= b + 16 * 1024) return 1'b0;
    if (eng) return (x % 16) == 0;
    return (x % 4) == 0;
  endfunction

  function automatic void flag(input logic [31:0] a);
    if (!m_err) m_eaddr = a;
    m_err = 1'b1;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".rd"}, interface_rd_data, m_rd);
    chk({tag, ".hrd"}, 128'(host_rd_data), 128'(m_hrd));
    chk({tag, ".hv"}, 128'(host_rd_valid), 128'(m_hv));
    chk({tag, ".err"}, 128'(err), 128'(m_err));
    chk({tag, ".eaddr"}, 128'(err_addr), 128'(m_eaddr));
  endtask

  task automatic step(input bit en, input bit wr, input logic [31:0] a,
                      input logic [4:0] c, input logic [127:0] d,
                      input bit hen, input bit hwr,
                      input logic [31:0] ha, input logic [31:0] hd);
    bit acc;
    int r;
    int ln;
    interface_en      = en;
    interface_rdwr    = wr;
    interface_addr    = a;
    interface_control = c;
    interface_wr_data = d;
    host_en           = hen;
    host_rdwr         = hwr;
    host_addr         = ha;
    host_wr_data      = hd;
    #1;
    acc = hen && !en;
    chk("hready", 128'(host_ready), 128'(acc));
    if (en) begin
      if (ok(a, 1'b1)) begin
        r = int'((a - BASE) / 16);
        if (wr) begin
          for (int i = 0; i < 4; i++)
            if (c[i]) mdl[r][32*i +: 32] = d[32*i +: 32];
        end else begin
          m_rd = mdl[r];
        end
      end else begin
        if (!wr) m_rd = '0;
        flag(a);
      end
    end
    m_hv = acc && !hwr;
    if (acc) begin
      if (ok(ha, 1'b0)) begin
        r  = int'((ha - BASE) / 16);
        ln = int'(((ha - BASE) / 4) % 4);
        if (hwr) mdl[r][32*ln +: 32] = hd;
        else m_hrd = mdl[r][32*ln +: 32];
      end else begin
        if (!hwr) m_hrd = '0;
        flag(ha);
      end
    end
    @(posedge clk);
    #1;
    check_all("step");
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] eng_addr();
    int r;
    r = $urandom_range(0, 15);
    case ($urandom_range(0, 9))
      0: return 32'h4000 + 32'(r * 16);
      1: return 32'(r * 16 + 4 * $urandom_range(1, 3));
      default: return 32'(r * 16);
    endcase
  endfunction

  function automatic logic [31:0] host_a();
    int r;
    r = $urandom_range(0, 15);
    case ($urandom_range(0, 9))
      0: return 32'h4000 + 32'(r * 16);
      1: return 32'(r * 16 + 2);
      default: return 32'(r * 16 + 4 * $urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    interface_en = 0; interface_rdwr = 0; interface_addr = 0;
    interface_control = 0; interface_wr_data = 0;
    host_en = 0; host_rdwr = 0; host_addr = 0; host_wr_data = 0;
    m_rd = '0; m_hrd = '0; m_hv = 0; m_err = 0; m_eaddr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    for (int r = 0; r < 16; r++)
      step(1, 1, 32'(r * 16), 5'h0F, r128(), 0, 0, 0, 0);

    step(1, 1, 32'h10, 5'h0F, {32'h4, 32'h3, 32'h2, 32'h1}, 0, 0, 0, 0);
    step(1, 0, 32'h10, 5'h00, '0, 0, 0, 0, 0);
    chk("roundtrip", interface_rd_data, {32'h4, 32'h3, 32'h2, 32'h1});

    step(1, 1, 32'h20, 5'h0F, '0, 0, 0, 0, 0);
    step(1, 1, 32'h20, 5'h15, {4{32'hFFFF_FFFF}}, 0, 0, 0, 0);
    step(1, 0, 32'h20, 5'h00, '0, 0, 0, 0, 0);
    chk("partial", interface_rd_data,
        {32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF});

    for (int k = 0; k < 3; k++)
      step(1, 0, 32'(k * 16), 5'h00, '0, 1, 0, 32'h14, 0);
    step(0, 0, 32'h0, 5'h00, '0, 1, 0, 32'h14, 0);
    chk("hblk.v", 128'(host_rd_valid), 128'(1));
    chk("hblk.d", 128'(host_rd_data), 128'(32'h2));

    step(1, 0, 32'h4000, 5'h00, '0, 0, 0, 0, 0);
    chk("oor.rd", interface_rd_data, '0);
    chk("oor.err", 128'(err), 128'(1));
    chk("oor.ea", 128'(err_addr), 128'(32'h4000));
    step(0, 0, 32'h0, 5'h00, '0, 1, 0, 32'h4004, 0);
    chk("oor.ea2", 128'(err_addr), 128'(32'h4000));

    step(1, 1, 32'h8, 5'h0F, r128(), 0, 0, 0, 0);
    step(1, 0, 32'h0, 5'h00, '0, 0, 0, 0, 0);

    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 4) < 3, $urandom_range(0, 1) == 1,
           eng_addr(), 5'($urandom), r128(),
           $urandom_range(0, 4) < 3, $urandom_range(0, 1) == 1,
           host_a(), $urandom);

    interface_en = 0;
    host_en = 1; host_rdwr = 0; host_addr = 32'h14;
    #1;
    chk("rmid.hready", 128'(host_ready), 128'(1));
    rst = 1'b0;
    m_rd = '0; m_hrd = '0; m_hv = 0; m_err = 0; m_eaddr = '0;
    #1;
    check_all("rmid0");
    host_en = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all("rmid");
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("rpost");

    step(0, 0, 32'h0, 5'h00, '0, 1, 0, 32'h4004, 0);
    chk("hbad.ea", 128'(err_addr), 128'(32'h4004));
    step(1, 0, 32'h8000, 5'h00, '0, 0, 0, 0, 0);
    chk("hbad.ea2", 128'(err_addr), 128'(32'h4004));
    step(1, 0, 32'h10, 5'h00, '0, 0, 0, 0, 0);
    step(1, 1, 32'h30, 5'h10, r128(), 0, 0, 0, 0);
    step(1, 0, 32'h30, 5'h00, '0, 0, 0, 0, 0);
    step(0, 0, 32'h0, 5'h00, '0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gemm_tile_mem.md
# gemm_tile_mem

Single-port 128-bit tile memory that answers the GEMM engine's memory interface as the responder: it serves the engine's 128-bit read and write requests with fixed one-cycle read latency. A secondary 32-bit host port lets the system CPU preload A/B tiles and read back C tiles. The host port only gets access when the engine is not using the array. It sits between the GEMM top level and the system interconnect, in place of a generic RAM.

## Interface
- DEPTH_LOG2, 10: log2 of row count; each row is 128 bits (default 16 KiB).
- BASE_ADDR, 32'h0000_0000: byte address of row 0; must be 16-byte aligned.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- interface_en  in  1  engine request strobe, one request per cycle.
- interface_rdwr  in  1  1 = write, 0 = read.
- interface_addr  in  32  engine byte address, 16-byte aligned.
- interface_control  in  5  [3:0] write lane mask (lane i = bits 32i+31:32i); [4] reserved, ignored.
- interface_wr_data  in  128  engine write data.
- interface_rd_data  out  128  engine read data, registered.
- host_en  in  1  host request; held stable until accepted.
- host_rdwr  in  1  1 = write, 0 = read.
- host_addr  in  32  host byte address, 4-byte aligned; [3:2] selects the lane.
- host_wr_data  in  32  host write data.
- host_ready  out  1  host request accepted this cycle.
- host_rd_data  out  32  host read data, registered.
- host_rd_valid  out  1  one-cycle pulse; host_rd_data is valid.
- err  out  1  sticky bad-address flag.
- err_addr  out  32  first offending address.

## Operation
- **Array**: 2^DEPTH_LOG2 rows × 4 lanes × 32 bits. Exactly one access per cycle. No reset of contents.
- **Row index**: row = (addr − BASE_ADDR) >> 4.
- **Address validity**
  - A request is valid when addr ≥ BASE_ADDR and row < 2^DEPTH_LOG2.
  - Engine requests must also have addr[3:0] = 0.
  - Host requests must also have addr[1:0] = 0.
- **Arbitration**
  - host_ready = host_en & ~interface_en (combinational).
  - The engine always wins. The host waits with its request held.
  - There is no fairness counter: the engine's schedule never saturates the interface.
- **Engine write**: writes each lane whose mask bit is 1. A mask of 4'b0000 is a legal no-op.
- **Engine read**
  - interface_rd_data ← row contents at the next edge.
  - The value holds until the next accepted engine read.
- **Host write**: writes lane host_addr[3:2] only.
- **Host read**
  - host_rd_data ← the selected lane at the next edge.
  - host_rd_valid pulses for 1 cycle.
- **Invalid address**
  - No array access.
  - A read returns all zeros, with the normal latency and pulse.
  - err is set. err_addr captures the address only if err was 0 beforehand.
  - If both ports are invalid in the same cycle, the engine address is recorded, since only the engine is accepted.
- **Read-after-write**: a read in cycle N+1 of a row written in cycle N returns the new data. No same-cycle hazard exists because there is one access per cycle.

## Timing
- **Reset values**: interface_rd_data = 0, host_rd_data = 0, host_rd_valid = 0, err = 0, err_addr = 0. host_ready is combinational, so it is 0 whenever host_en = 0.
- **Read latency**: 1 cycle on both ports. Request at edge N gives data valid after edge N+1.
- **Engine throughput**: back-to-back reads and writes at 1 per cycle with no stall. This is mandatory because the engine has no wait input.
- **Host**: accepted in any cycle where interface_en = 0. A read is complete on the host_rd_valid pulse. A write is complete at acceptance.
- **Reset asserted mid-operation**: takes effect immediately (asynchronous). Any read response in flight is discarded, host_rd_valid = 0 while rst = 0, and no array write happens in that cycle.
- **Reset deasserted**: the first request is accepted on the first rising edge with rst = 1.

## Test plan
- **Engine round trip**: engine write 0x0000_0010, data {32'h4,32'h3,32'h2,32'h1}, mask 4'hF; then read same address next cycle → interface_rd_data = {4,3,2,1} one cycle after the read.
- **Partial write**: write mask 4'b0101 with data all 32'hFFFF_FFFF over a row preloaded to zeros → read returns {0,FFFF_FFFF,0,FFFF_FFFF}.
- **Host blocked**: host read of 0x14 held while the engine issues 3 consecutive reads → host_ready = 0 for those 3 cycles, then 1. host_rd_valid pulses on the following cycle with lane 1 = 32'h2.
- **Out-of-range**: DEPTH_LOG2 = 10, engine read of 0x4000 → interface_rd_data = 0, err = 1, err_addr = 0x4000. A later bad host address 0x4004 leaves err_addr = 0x4000.
- **Misaligned engine access**: engine write to 0x0000_0008 → array unchanged (readback of row 0 unchanged), err = 1.
- **Reset mid-read**: host read accepted, then rst driven low before the next edge → host_rd_valid never pulses. All outputs are 0 while rst = 0.
